// File: rtl/pwm_ramp_ctrl_if.sv
// Command/config/output bundle between the host sequencer side and pwm_ramp_ctrl.
// Latency: n/a (signal bundle only).
// Backpressure: none; commands are single-cycle pulses, outputs are level/pulse.
// Ports: cmd_start/cmd_stop pulses, cfg_* ramp parameters (host -> ctrl);
//        period_reg, duty_sel, enables, i_DC, i_DC_valid, busy, done, err (ctrl -> core/host).
interface pwm_ramp_ctrl_if #(
  parameter int W  = 16,
  parameter int IW = 8
);
  logic          cmd_start;
  logic          cmd_stop;
  logic [W-1:0]  cfg_period;
  logic [W-1:0]  cfg_start_duty;
  logic [W-1:0]  cfg_target_duty;
  logic [W-1:0]  cfg_step;
  logic [IW-1:0] cfg_interval;

  logic [W-1:0]  period_reg;
  logic          duty_sel;
  logic          pwm_core_EN;
  logic          main_counter_EN;
  logic          o_pwm_EN;
  logic [W-1:0]  i_DC;
  logic          i_DC_valid;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output cmd_start, cmd_stop, cfg_period, cfg_start_duty, cfg_target_duty,
           cfg_step, cfg_interval,
    input  period_reg, duty_sel, pwm_core_EN, main_counter_EN, o_pwm_EN,
           i_DC, i_DC_valid, busy, done, err
  );

  modport slave (
    input  cmd_start, cmd_stop, cfg_period, cfg_start_duty, cfg_target_duty,
           cfg_step, cfg_interval,
    output period_reg, duty_sel, pwm_core_EN, main_counter_EN, o_pwm_EN,
           i_DC, i_DC_valid, busy, done, err
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer stepping the pwm_core duty word at PWM period boundaries.
// Latency: commands take effect on the sampling edge; duty steps every P*I cycles.
// Backpressure: none; cmd_start is ignored during soft-stop, cmd_stop overrides cmd_start.
// Ports: clk, rst (sync, active-high); io_bus slave modport carrying commands, config
//        and the registered pwm_core drive signals (period_reg, enables, i_DC, status).
module pwm_ramp_ctrl #(
  parameter int W  = 16,
  parameter int IW = 8
) (
  input  logic           clk,
  input  logic           rst,
  pwm_ramp_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_pcnt, w_pcnt_nxt;
  logic [IW-1:0] r_icnt, w_icnt_nxt;
  logic [W-1:0]  r_p, w_p_nxt;
  logic [W-1:0]  r_t, w_t_nxt;
  logic [W-1:0]  r_step, w_step_nxt;
  logic [IW-1:0] r_int, w_int_nxt;
  logic [W-1:0]  r_dc, w_dc_nxt;
  logic          r_en, w_en_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;

  logic          w_start;
  logic          w_boundary;
  logic          w_fire;
  logic [W:0]    w_up_sum;
  logic [W:0]    w_dn_lim;
  logic [W-1:0]  w_dc_step;
  logic [W-1:0]  w_cfg_s;
  logic [W-1:0]  w_cfg_t;
  logic [W-1:0]  w_cfg_step;
  logic [IW-1:0] w_cfg_int;

  // Stop has priority: a simultaneous start is dropped.
  assign w_start    = io_bus.cmd_start & ~io_bus.cmd_stop;
  assign w_boundary = (r_pcnt == r_p - W'(1));
  // ">=" rather than "==" so a retarget that shrinks I with icnt already past it still fires.
  assign w_fire     = w_boundary && (r_icnt >= r_int - IW'(1));

  // One step toward r_t in W+1 bits: neither the sum nor the lower limit can wrap.
  assign w_up_sum  = {1'b0, r_dc} + {1'b0, r_step};
  assign w_dn_lim  = {1'b0, r_t} + {1'b0, r_step};
  assign w_dc_step = (r_dc < r_t)
                   ? ((w_up_sum >= {1'b0, r_t}) ? r_t : w_up_sum[W-1:0])
                   : (({1'b0, r_dc} <= w_dn_lim) ? r_t : r_dc - r_step);

  assign w_cfg_s    = (io_bus.cfg_start_duty  > io_bus.cfg_period) ? io_bus.cfg_period : io_bus.cfg_start_duty;
  assign w_cfg_t    = (io_bus.cfg_target_duty > io_bus.cfg_period) ? io_bus.cfg_period : io_bus.cfg_target_duty;
  assign w_cfg_step = (io_bus.cfg_step == '0)     ? W'(1)  : io_bus.cfg_step;
  assign w_cfg_int  = (io_bus.cfg_interval == '0) ? IW'(1) : io_bus.cfg_interval;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_icnt  <= '0;
      r_p     <= '0;
      r_t     <= '0;
      r_step  <= '0;
      r_int   <= '0;
      r_dc    <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_icnt  <= w_icnt_nxt;
      r_p     <= w_p_nxt;
      r_t     <= w_t_nxt;
      r_step  <= w_step_nxt;
      r_int   <= w_int_nxt;
      r_dc    <= w_dc_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_icnt_nxt  = r_icnt;
    w_p_nxt     = r_p;
    w_t_nxt     = r_t;
    w_step_nxt  = r_step;
    w_int_nxt   = r_int;
    w_dc_nxt    = r_dc;
    w_en_nxt    = r_en;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    // Counters free-run whenever the core is active; branches below may override.
    if (r_state != IDLE) begin
      w_pcnt_nxt = w_boundary ? '0 : r_pcnt + W'(1);
      if (w_boundary) begin
        w_icnt_nxt = w_fire ? '0 : r_icnt + IW'(1);
      end
    end

    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (io_bus.cfg_period == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_p_nxt    = io_bus.cfg_period;
            w_t_nxt    = w_cfg_t;
            w_step_nxt = w_cfg_step;
            w_int_nxt  = w_cfg_int;
            w_dc_nxt   = w_cfg_s;
            w_en_nxt   = 1'b1;
            w_pcnt_nxt = '0;
            w_icnt_nxt = '0;
            if (w_cfg_s == w_cfg_t) begin
              w_state_nxt = HOLD;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = RAMP;
            end
          end
        end
      end
      RAMP, HOLD: begin
        if (io_bus.cmd_stop) begin
          w_t_nxt     = '0;
          w_state_nxt = STOP;
        end else if (w_start) begin
          if (io_bus.cfg_period == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_t_nxt    = w_cfg_t;
            w_step_nxt = w_cfg_step;
            w_int_nxt  = w_cfg_int;
            if (io_bus.cfg_period != r_p) begin
              w_p_nxt    = io_bus.cfg_period;
              w_pcnt_nxt = '0;
              w_icnt_nxt = '0;
            end
            if (r_dc == w_cfg_t) begin
              w_state_nxt = HOLD;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = RAMP;
            end
          end
        end else if (r_state == RAMP && w_fire) begin
          w_dc_nxt = w_dc_step;
          if (w_dc_step == r_t) begin
            w_state_nxt = HOLD;
            w_done_nxt  = 1'b1;
          end
        end
      end
      STOP: begin
        // Once at zero, hold one more full period so the core finishes cleanly.
        if (r_dc == '0) begin
          if (w_boundary) begin
            w_state_nxt = IDLE;
            w_en_nxt    = 1'b0;
            w_pcnt_nxt  = '0;
            w_icnt_nxt  = '0;
          end
        end else if (w_fire) begin
          w_dc_nxt = w_dc_step;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign io_bus.period_reg      = r_p;
  assign io_bus.duty_sel        = r_en;
  assign io_bus.pwm_core_EN     = r_en;
  assign io_bus.main_counter_EN = r_en;
  assign io_bus.o_pwm_EN        = r_en;
  assign io_bus.i_DC            = r_dc;
  assign io_bus.i_DC_valid      = r_en;
  assign io_bus.busy            = r_busy;
  assign io_bus.done            = r_done;
  assign io_bus.err             = r_err;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus random commands,
// every cycle compared against a cycle-count reference model.
module tb_pwm_ramp_ctrl;
  logic clk;
  logic rst;

  pwm_ramp_ctrl_if #(.W(16), .IW(8)) bus ();

  pwm_ramp_ctrl #(.W(16), .IW(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 ramping, 2 holding, 3 stopping.
  // m_t counts cycles since the last step or counter restart.
  int m_mode = 0, m_P = 0, m_T = 0, m_step = 0, m_I = 0, m_dc = 0;
  int m_en = 0, m_preg = 0, m_done = 0, m_err = 0, m_t = 0;

  function automatic int toward(input int d, input int t, input int s);
    if (d < t) return (d + s > t) ? t : d + s;
    return (d - s < t) ? t : d - s;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk) begin
    int cp, bnd, fire;
    bit strt;
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      m_mode = 0; m_P = 0; m_T = 0; m_step = 0; m_I = 0;
      m_dc = 0; m_en = 0; m_preg = 0; m_t = 0;
    end else begin
      cp   = int'(bus.cfg_period);
      strt = bus.cmd_start && !bus.cmd_stop;
      bnd  = 0;
      fire = 0;
      if (m_mode != 0) begin
        bnd  = (((m_t + 1) % m_P) == 0) ? 1 : 0;
        fire = (bnd != 0 && ((m_t + 1) / m_P) >= m_I) ? 1 : 0;
        m_t  = (fire != 0) ? 0 : m_t + 1;
      end
      case (m_mode)
        0: if (strt) begin
          if (cp == 0) m_err = 1;
          else begin
            m_P    = cp;
            m_preg = cp;
            m_T    = imin(int'(bus.cfg_target_duty), cp);
            m_dc   = imin(int'(bus.cfg_start_duty), cp);
            m_step = (bus.cfg_step == 0) ? 1 : int'(bus.cfg_step);
            m_I    = (bus.cfg_interval == 0) ? 1 : int'(bus.cfg_interval);
            m_en   = 1;
            m_t    = 0;
            if (m_dc == m_T) begin m_mode = 2; m_done = 1; end
            else m_mode = 1;
          end
        end
        1, 2: begin
          if (bus.cmd_stop) begin
            m_T = 0;
            m_mode = 3;
          end else if (strt) begin
            if (cp == 0) m_err = 1;
            else begin
              m_T    = imin(int'(bus.cfg_target_duty), cp);
              m_step = (bus.cfg_step == 0) ? 1 : int'(bus.cfg_step);
              m_I    = (bus.cfg_interval == 0) ? 1 : int'(bus.cfg_interval);
              if (cp != m_P) begin m_P = cp; m_preg = cp; m_t = 0; end
              if (m_dc == m_T) begin m_mode = 2; m_done = 1; end
              else m_mode = 1;
            end
          end else if (m_mode == 1 && fire != 0) begin
            m_dc = toward(m_dc, m_T, m_step);
            if (m_dc == m_T) begin m_mode = 2; m_done = 1; end
          end
        end
        3: begin
          if (m_dc == 0) begin
            if (bnd != 0) begin m_mode = 0; m_en = 0; m_t = 0; end
          end else if (fire != 0) begin
            m_dc = toward(m_dc, 0, m_step);
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [7:0] fl_obs, fl_exp;
    fl_obs = {bus.duty_sel, bus.pwm_core_EN, bus.main_counter_EN, bus.o_pwm_EN,
              bus.i_DC_valid, bus.busy, bus.done, bus.err};
    fl_exp = {m_en[0], m_en[0], m_en[0], m_en[0], m_en[0], (m_mode != 0),
              m_done[0], m_err[0]};
    chk("model_dc",    32'(bus.i_DC),       32'(m_dc));
    chk("model_preg",  32'(bus.period_reg), 32'(m_preg));
    chk("model_flags", 32'(fl_obs),         32'(fl_exp));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_check();
    end
  endtask

  task automatic set_cfg(input int p, input int s, input int t, input int st, input int iv);
    bus.cfg_period      = 16'(p);
    bus.cfg_start_duty  = 16'(s);
    bus.cfg_target_duty = 16'(t);
    bus.cfg_step        = 16'(st);
    bus.cfg_interval    = 8'(iv);
  endtask

  task automatic pulse_start();
    bus.cmd_start = 1'b1;
    tick(1);
    bus.cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.cmd_stop = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dc"},   32'(bus.i_DC), 0);
    chk({tag, "_preg"}, 32'(bus.period_reg), 0);
    chk({tag, "_outs"}, 32'({bus.duty_sel, bus.pwm_core_EN, bus.main_counter_EN, bus.o_pwm_EN,
                             bus.i_DC_valid, bus.busy, bus.done, bus.err}), 0);
  endtask

  initial begin
    int seq2[3];
    int r, p;
    seq2 = '{10, 20, 25};
    rst = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    tick(2);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(3);

    // Ramp up 0 -> 50 in steps of 10 every 2 periods of 100.
    set_cfg(100, 0, 50, 10, 2);
    pulse_start();
    chk("up_busy", 32'(bus.busy), 1);
    chk("up_en",   32'(bus.pwm_core_EN), 1);
    chk("up_s",    32'(bus.i_DC), 0);
    chk("up_preg", 32'(bus.period_reg), 100);
    for (int n = 1; n <= 5; n++) begin
      tick(199);
      chk("up_before", 32'(bus.i_DC), 32'(10 * (n - 1)));
      tick(1);
      chk("up_step", 32'(bus.i_DC), 32'(10 * n));
      chk("up_done", 32'(bus.done), (n == 5) ? 1 : 0);
    end
    tick(1);
    chk("up_done_once", 32'(bus.done), 0);
    pulse_stop();
    tick(1300);
    chk("up_idle", 32'(bus.busy), 0);

    // Partial final step 0 -> 25 by 10.
    set_cfg(100, 0, 25, 10, 1);
    pulse_start();
    for (int n = 0; n < 3; n++) begin
      tick(100);
      chk("part_step", 32'(bus.i_DC), 32'(seq2[n]));
      chk("part_done", 32'(bus.done), (n == 2) ? 1 : 0);
    end
    tick(500);
    chk("part_hold", 32'(bus.i_DC), 25);
    pulse_stop();
    tick(600);
    chk("part_idle", 32'(bus.busy), 0);

    // Clamped target, zero step/interval.
    pulse_rst();
    set_cfg(100, 98, 150, 0, 0);
    pulse_start();
    chk("clamp_s", 32'(bus.i_DC), 98);
    tick(100);
    chk("clamp_1", 32'(bus.i_DC), 99);
    chk("clamp_nodone", 32'(bus.done), 0);
    tick(100);
    chk("clamp_2", 32'(bus.i_DC), 100);
    chk("clamp_done", 32'(bus.done), 1);

    // Soft-stop from HOLD at 50.
    pulse_rst();
    set_cfg(100, 50, 50, 25, 1);
    pulse_start();
    chk("stop_hold_done", 32'(bus.done), 1);
    pulse_stop();
    tick(98);
    chk("stop_pre", 32'(bus.i_DC), 50);
    tick(1);
    chk("stop_25", 32'(bus.i_DC), 25);
    tick(99);
    chk("stop_25b", 32'(bus.i_DC), 25);
    tick(1);
    chk("stop_0", 32'(bus.i_DC), 0);
    tick(99);
    chk("stop_en_held", 32'(bus.o_pwm_EN), 1);
    tick(1);
    chk("stop_en_off", 32'({bus.pwm_core_EN, bus.main_counter_EN, bus.o_pwm_EN, bus.duty_sel}), 0);
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_valid", 32'(bus.i_DC_valid), 0);

    // Rejected start.
    set_cfg(0, 10, 20, 1, 1);
    pulse_start();
    chk("err_pulse", 32'(bus.err), 1);
    chk("err_no_en", 32'(bus.pwm_core_EN), 0);
    tick(1);
    chk("err_once", 32'(bus.err), 0);

    // Start and stop together during RAMP: stop wins.
    set_cfg(100, 40, 90, 10, 1);
    pulse_start();
    tick(9);
    set_cfg(100, 40, 100, 10, 1);
    bus.cmd_start = 1'b1;
    bus.cmd_stop  = 1'b1;
    tick(1);
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    tick(89);
    chk("both_pre", 32'(bus.i_DC), 40);
    tick(1);
    chk("both_down", 32'(bus.i_DC), 30);
    tick(450);
    chk("both_idle", 32'(bus.busy), 0);

    // Reset mid-ramp, then a fresh start behaves like power-up.
    set_cfg(100, 0, 50, 10, 2);
    pulse_start();
    tick(349);
    chk("mid_dc", 32'(bus.i_DC), 10);
    rst = 1'b1;
    tick(1);
    chk_all_zero("midrst");
    rst = 1'b0;
    pulse_start();
    tick(199);
    chk("rerun_pre", 32'(bus.i_DC), 0);
    tick(1);
    chk("rerun_step", 32'(bus.i_DC), 10);

    // Downward step that would wrap in W bits: retarget to a tiny period.
    pulse_rst();
    set_cfg(60000, 60000, 60000, 1, 1);
    pulse_start();
    chk("wide_hold", 32'(bus.i_DC), 60000);
    set_cfg(2, 0, 2, 65535, 1);
    pulse_start();
    chk("wide_preg", 32'(bus.period_reg), 2);
    tick(1);
    chk("wide_pre", 32'(bus.i_DC), 60000);
    tick(1);
    chk("wide_sat", 32'(bus.i_DC), 2);
    chk("wide_done", 32'(bus.done), 1);
    pulse_stop();
    tick(10);
    chk("wide_idle", 32'(bus.busy), 0);

    // Random commands against the model.
    pulse_rst();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      p = $urandom_range(0, 15);
      if (r % 2 == 1 && m_P != 0) p = m_P;
      set_cfg(p, $urandom_range(0, p + 4), $urandom_range(0, p + 4),
              $urandom_range(0, 6), $urandom_range(0, 3));
      if (r < 25) pulse_start();
      else if (r < 35) pulse_stop();
      else if (r < 38) begin
        bus.cmd_start = 1'b1;
        bus.cmd_stop  = 1'b1;
        tick(1);
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
      end else if (r < 40) pulse_rst();
      tick($urandom_range(1, 20));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencer that drives the control and configuration inputs of `pwm_core`. It enables the core, then ramps the external duty word (`i_DC`) from a start value to a target in programmable steps at PWM-period boundaries (soft-start). On command it ramps the duty back down to zero (soft-stop) and disables the core. It sits between the host command interface and `pwm_core` on the same clock.

## Interface
- `W`, default 16: width of the period and duty words; must match `pwm_core`.
- `IW`, default 8: width of the step-interval field, counted in PWM periods.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_start`  in  1  single-cycle pulse; latches the `cfg_*` inputs and starts or retargets a ramp.
- `cmd_stop`  in  1  single-cycle pulse; starts the soft-stop sequence.
- `cfg_period`  in  W  PWM period in clock cycles.
- `cfg_start_duty`  in  W  initial duty value.
- `cfg_target_duty`  in  W  final duty value.
- `cfg_step`  in  W  duty increment per step; 0 is treated as 1.
- `cfg_interval`  in  IW  number of PWM periods per step; 0 is treated as 1.
- `period_reg`  out  W  period word driven to `pwm_core`.
- `duty_sel`  out  1  driven to `pwm_core`; 1 selects `i_DC`.
- `pwm_core_EN`, `main_counter_EN`, `o_pwm_EN`  out  1 each  enables driven to `pwm_core`.
- `i_DC`  out  W  current duty word.
- `i_DC_valid`  out  1  high whenever `duty_sel` = 1.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the target is reached.
- `err`  out  1  one-cycle pulse when `cmd_start` is rejected.

## Operation
- State machine states: IDLE, RAMP, HOLD, STOP.
- All outputs are registered. After reset, every output is 0 and the state is IDLE.
- Period counter `pcnt` runs 0..P-1, where P is the latched period. A boundary is the cycle in which `pcnt` = P-1; `pcnt` wraps to 0 on the next edge.
- Interval counter `icnt` increments on each boundary. When `icnt` reaches I-1 (I is the latched interval) at a boundary, a step fires and `icnt` resets to 0.
- IDLE, on `cmd_start`:
  - If `cfg_period` = 0, pulse `err` and stay in IDLE.
  - Otherwise latch P, S = min(`cfg_start_duty`, P), T = min(`cfg_target_duty`, P), the step and I.
  - Drive `i_DC` = S and `period_reg` = P. Set all three enables, `duty_sel` and `i_DC_valid` to 1. Clear `pcnt` and `icnt`.
  - Go to RAMP, or directly to HOLD with a `done` pulse if S = T.
- RAMP, on each step:
  - Move `i_DC` toward T by the step, saturating exactly at T with no overshoot. Arithmetic is W+1 bits, so the value never wraps.
  - When `i_DC` becomes T, go to HOLD and pulse `done` in the same edge.
- HOLD: `i_DC` is constant.
- `cmd_start` in RAMP or HOLD retargets the ramp:
  - Latch new T, step and I. Keep the current `i_DC`.
  - If `cfg_period` differs from P, update P and `period_reg` and clear `pcnt` and `icnt`.
  - Start/clamp rules are as in IDLE, except that S is ignored.
  - `cfg_period` = 0 pulses `err` and changes nothing.
- `cmd_stop` in RAMP or HOLD: set T = 0 and go to STOP.
- STOP:
  - Step `i_DC` down toward 0 using the current step and I.
  - When `i_DC` = 0, at the next boundary clear all enables, `duty_sel` and `i_DC_valid`, and go to IDLE.
  - `cmd_start` is ignored in STOP.
- `cmd_stop` in IDLE: no effect.
- `cmd_start` and `cmd_stop` in the same cycle: stop wins.
- `rst` asserted in any state, including mid-ramp: on the next edge all outputs are 0, the state is IDLE and all counters are 0.

## Timing
- `cmd_start` sampled at edge k: enables, `i_DC` = S and `busy` are visible from edge k.
- First step takes effect at edge k + P·I. Each later step follows P·I cycles after the previous one.
- `done` is high for exactly one cycle, coincident with the final `i_DC` update.
- Soft-stop: the disable occurs P cycles after the edge at which `i_DC` reached 0, at that later boundary, regardless of `icnt`.
- `err` is a one-cycle pulse at the edge that samples the rejected `cmd_start`.

## Test plan
- Ramp up: P=100, S=0, T=50, step=10, I=2 -> `i_DC` is 10, 20, 30, 40, 50 at start+200, +400, +600, +800, +1000; `done` pulses at +1000; state is HOLD.
- Partial final step: P=100, S=0, T=25, step=10, I=1 -> `i_DC` sequence 10, 20, 25; never exceeds 25.
- Clamp and zero fields: T=150, step=0, I=0, P=100, S=98 -> `i_DC` is 99 at start+100, then 100 at start+200; `done` pulses there.
- Soft-stop from HOLD at duty 50, step=25, I=1, P=100 -> `i_DC` is 25, then 0, one period apart; all enables drop 100 cycles after reaching 0; `busy` = 0.
- Errors and priority: `cmd_start` with `cfg_period`=0 -> `err` pulse, no enables. `cmd_start` and `cmd_stop` in the same cycle during RAMP -> state becomes STOP.
- Reset mid-ramp: assert `rst` at start+350 -> every output is 0 one edge later. A new `cmd_start` afterwards behaves exactly as from power-up.
